// File: rtl/canny_nms_frame_seq.sv
// Frame sequencer for the Canny NMS stage: raster position tracking, window-valid
// generation and sof/eol/eof tags delayed to line up with the NMS output.
module canny_nms_frame_seq #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int LAT   = 2,
    parameter int CW    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          win_valid,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    input  logic          nms_valid,
    output logic          m_valid,
    output logic          m_sof,
    output logic          m_eol,
    output logic          m_eof,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST   = CW'(IMG_H - 1);
    localparam logic [CW-1:0] TWO        = CW'(2);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic [DW-1:0] drn_q, drn_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    // Each stage holds {valid, sof, eol, eof}.
    logic [3:0]    tag_q [LAT];
    logic [3:0]    tag_d [LAT];

    logic accept, sof, eol, eof;

    assign pix_ready = (state_q == RUN);
    assign accept    = pix_valid & pix_ready;
    assign win_valid = accept & (row_q >= TWO) & (col_q >= TWO);
    assign sof       = win_valid & (row_q == TWO) & (col_q == TWO);
    assign eol       = win_valid & (col_q == COL_LAST);
    assign eof       = eol & (row_q == ROW_LAST);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        drn_d   = drn_q;
        done_d  = 1'b0;
        // Once IDLE, NMS may still flush windows of an aborted frame; ignore them.
        err_d   = err_q | ((state_q != IDLE) & (nms_valid != tag_q[LAT-1][3]));
        tag_d[0] = {win_valid, sof, eol, eof};
        for (int i = 1; i < LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            drn_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (drn_q == DRAIN_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    drn_d = drn_q + DW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            row_d   = '0;
            col_d   = '0;
            drn_d   = '0;
            done_d  = 1'b0;
            for (int i = 0; i < LAT; i++) begin
                tag_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            drn_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            drn_q   <= drn_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign row     = row_q;
    assign col     = col_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign m_valid = tag_q[LAT-1][3];
    assign m_sof   = tag_q[LAT-1][2];
    assign m_eol   = tag_q[LAT-1][1];
    assign m_eof   = tag_q[LAT-1][0];
endmodule

// File: tb/tb_canny_nms_frame_seq.sv
// Bench for canny_nms_frame_seq on a 5x4 frame: a raster/timestamp model predicts
// every output each cycle; per-frame literal tag masks pin the model.
module tb_canny_nms_frame_seq;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int L  = 2;
    localparam int CW = 12;
    localparam int NF = W * H;

    logic          clk, rst_n, start, abort, pix_valid, nms_valid;
    logic          pix_ready, win_valid, m_valid, m_sof, m_eol, m_eof, busy, done, err;
    logic [CW-1:0] col, row;

    canny_nms_frame_seq #(.IMG_W(W), .IMG_H(H), .LAT(L), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .win_valid(win_valid),
        .col(col), .row(row), .nms_valid(nms_valid),
        .m_valid(m_valid), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .busy(busy), .done(done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in NMS: out_valid is win_valid delayed by nms_idx+1 cycles.
    logic [3:0] nms_sr;
    logic [1:0] nms_idx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) nms_sr <= '0;
        else        nms_sr <= {nms_sr[2:0], win_valid};
    end
    assign nms_valid = nms_sr[nms_idx];

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Model state
    bit         run_m, busy_m, err_m;
    int         k_m, done_cyc, last_win_cyc, f_mv;
    logic [7:0] f_sof, f_eol, f_eof;
    logic [3:0] exp_tag [0:4095];

    initial begin
        int r, cc;
        bit acc, win, sof, eol, eof, b0;
        for (int i = 0; i < 4096; i++) exp_tag[i] = 4'b0;
        run_m = 0; busy_m = 0; err_m = 0; k_m = 0; done_cyc = -1;
        last_win_cyc = 0; f_mv = 0; f_sof = 0; f_eol = 0; f_eof = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run_m = 0; busy_m = 0; err_m = 0; k_m = 0; done_cyc = -1;
                for (int i = 0; i <= L + 1; i++) exp_tag[cyc+i] = 4'b0;
            end
            r   = run_m ? k_m / W : 0;
            cc  = run_m ? k_m % W : 0;
            acc = run_m && pix_valid;
            win = acc && r >= 2 && cc >= 2;
            sof = win && r == 2 && cc == 2;
            eol = win && cc == W - 1;
            eof = eol && r == H - 1;

            chk("pix_ready", int'(pix_ready), int'(run_m));
            chk("win_valid", int'(win_valid), int'(win));
            chk("row", int'(row), r);
            chk("col", int'(col), cc);
            chk("m_valid", int'(m_valid), int'(exp_tag[cyc][3]));
            chk("m_sof", int'(m_sof), int'(exp_tag[cyc][2]));
            chk("m_eol", int'(m_eol), int'(exp_tag[cyc][1]));
            chk("m_eof", int'(m_eof), int'(exp_tag[cyc][0]));
            chk("busy", int'(busy), int'(busy_m));
            chk("done", int'(done), int'(cyc == done_cyc));
            chk("err", int'(err), int'(err_m));

            if (m_valid) begin
                $display("out %0d: sof=%b eol=%b eof=%b (cycle %0d)", f_mv + 1, m_sof, m_eol, m_eof, cyc);
                if (f_mv < 8) begin
                    f_sof[f_mv[2:0]] = m_sof;
                    f_eol[f_mv[2:0]] = m_eol;
                    f_eof[f_mv[2:0]] = m_eof;
                end
                f_mv++;
            end
            if (win_valid && row == CW'(H - 1) && col == CW'(W - 1)) last_win_cyc = cyc;
            if (cyc == done_cyc) begin
                chk("frame_outputs", f_mv, 6);
                chk("sof_mask", int'(f_sof), 'h01);
                chk("eol_mask", int'(f_eol), 'h24);
                chk("eof_mask", int'(f_eof), 'h20);
                chk("done_latency", cyc - last_win_cyc, 3);
            end

            if (rst_n) begin
                b0 = busy_m;
                if (busy_m && (nms_valid != exp_tag[cyc][3])) err_m = 1;
                if (abort && b0) begin
                    run_m = 0; busy_m = 0; k_m = 0;
                    for (int i = 1; i <= L; i++) exp_tag[cyc+i] = 4'b0;
                end else begin
                    exp_tag[cyc+L] = win ? {1'b1, sof, eol, eof} : 4'b0;
                    if (acc) begin
                        k_m++;
                        if (k_m == NF) begin
                            run_m = 0;
                            done_cyc = cyc + L + 1;
                        end
                    end
                    if (cyc == done_cyc) busy_m = 0;
                    if (!b0 && start && !abort) begin
                        run_m = 1; busy_m = 1; k_m = 0;
                        f_mv = 0; f_sof = 0; f_eol = 0; f_eof = 0;
                    end
                end
            end
            cyc++;
        end
    end

    // Called just after a posedge; returns just after a posedge.
    task automatic run_frame(input bit toggle, input int again_k, input int abort_k);
        int k = 0;
        bit ph = 0;
        bit pv;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (k < NF) begin
            pv = !toggle || !ph;
            ph = !ph;
            pix_valid = pv;
            start = pv && k == again_k;
            abort = pv && k == abort_k;
            @(posedge clk); #1;
            if (pv) k = (k == abort_k) ? NF : k + 1;
        end
        pix_valid = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; nms_idx = 2'd1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_frame(1'b0, -1, -1);
        run_frame(1'b1, -1, -1);
        run_frame(1'b0, 6, -1);
        run_frame(1'b0, -1, 13);
        run_frame(1'b0, -1, -1);
        nms_idx = 2'd2;
        run_frame(1'b0, -1, -1);
        nms_idx = 2'd1;
        run_frame(1'b1, -1, -1);

        // Asynchronous reset in the middle of a frame.
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0; pix_valid = 1'b1;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_pix_ready", int'(pix_ready), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_win_valid", int'(win_valid), 0);
        chk("async_m_valid", int'(m_valid), 0);
        chk("async_err", int'(err), 0);
        chk("async_col", int'(col), 0);
        chk("async_row", int'(row), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 pix_valid = 1'b0;
        run_frame(1'b0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
